// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Define MULDIV_EARLY_OUT_EN to skip CALC for zero operands and div special cases.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FINISH, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic              dz_q, dz_d;
  logic              ov_q, ov_d;

  logic              is_div, sgn_a, sgn_b;
  logic              neg_a, neg_b, zero_b, ovf, early;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     sum, rem_sh, diff;
  logic [2*XLEN-1:0] mul_nx, div_nx, prod;
  logic [XLEN-1:0]   quo, rem, sel;

  assign is_div = func3[2];
  assign sgn_a  = is_div ? !func3[0] : (func3 != 3'b011);
  assign sgn_b  = is_div ? !func3[0] : !func3[1];
  assign neg_a  = sgn_a & opA[XLEN-1];
  assign neg_b  = sgn_b & opB[XLEN-1];
  assign mag_a  = neg_a ? -opA : opA;
  assign mag_b  = neg_b ? -opB : opB;
  assign zero_b = (opB == '0);
  assign ovf    = is_div & !func3[0] & (&opB)
                & (opA == {1'b1, {(XLEN-1){1'b0}}});

`ifdef MULDIV_EARLY_OUT_EN
  assign early = is_div ? (zero_b | ovf) : ((opA == '0) | zero_b);
`else
  assign early = 1'b0;
`endif

  // Multiply: acc = {partial product, remaining multiplier bits}
  assign sum    = {1'b0, acc_q[2*XLEN-1:XLEN]}
                + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_nx = {sum, acc_q[XLEN-1:1]};

  // Divide: acc = {remainder, quotient/dividend bits}
  assign rem_sh = acc_q[2*XLEN-1:XLEN-1];
  assign diff   = rem_sh - {1'b0, b_q};
  assign div_nx = diff[XLEN]
                ? {acc_q[2*XLEN-2:0], 1'b0}
                : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  assign prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quo  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    sel = '0;
    unique case (f3_q)
      3'b000:                 sel = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: sel = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         sel = dz_q ? '1 : (ov_q ? a_q : quo);
      default:                sel = dz_q ? a_q : (ov_q ? '0 : rem);
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          f3_d    = func3;
          a_d     = opA;
          b_d     = mag_b;
          acc_d   = {{XLEN{1'b0}}, zero_b ? '0 : mag_a};
          sa_d    = neg_a;
          sb_d    = neg_b;
          dz_d    = is_div & zero_b;
          ov_d    = ovf;
          cnt_d   = CW'(XLEN - 1);
          state_d = early ? FINISH : CALC;
        end
      end
      CALC: begin
        acc_d = f3_q[2] ? div_nx : mul_nx;
        if (cnt_q == '0) state_d = FINISH;
        else cnt_d = cnt_q - CW'(1);
      end
      FINISH: begin
        res_d   = sel;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      res_q   <= res_d;
    end
  end

  assign stall  = (start && state_q == IDLE)
                || state_q == CALC || state_q == FINISH;
  assign done   = (state_q == DONE);
  assign result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + random bench for muldiv_unit against an arithmetic model.
// Expected latency follows MULDIV_EARLY_OUT_EN when defined.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  func3;
  logic [31:0] opA, opB;
  logic        stall, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .func3(func3),
    .opA(opA), .opB(opB), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint as, bs, au, bu, p;
    logic ov;
    as = $signed(a);
    bs = $signed(b);
    au = a;
    bu = b;
    ov = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
    case (f)
      3'd0: begin p = as * bs; return p[31:0]; end
      3'd1: begin p = as * bs; return p[63:32]; end
      3'd2: begin p = as * bu; return p[63:32]; end
      3'd3: begin p = au * bu; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hffff_ffff;
        if (ov) return 32'h8000_0000;
        p = as / bs; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hffff_ffff;
        p = au / bu; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ov) return 32'h0;
        p = as % bs; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = au % bu; return p[31:0];
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    logic sp;
    if (f[2])
      sp = (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hffff_ffff);
    else
      sp = (a == 0) || (b == 0);
    if (sp) return 2;
`endif
    return 34;
  endfunction

  // start held high until done, as a frozen pipeline would
  task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, output int dcyc,
                        output int scnt, output logic [31:0] r);
    @(negedge clk);
    start = 1'b1; func3 = f; opA = a; opB = b;
    dcyc = -1; scnt = 0; r = 'x;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (stall) scnt++;
      if (done) begin
        dcyc = c; r = result; break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_op(input string tag, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b);
    int dcyc, scnt, lat;
    logic [31:0] r;
    lat = exp_lat(f, a, b);
    run_op(f, a, b, dcyc, scnt, r);
    chk({tag, "_res"}, r, model(f, a, b));
    chk({tag, "_done_cyc"}, dcyc, lat);
    chk({tag, "_stall_cyc"}, scnt, lat);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hffff_ffff;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dseen;
    logic [2:0] rf;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; func3 = '0; opA = '0; opB = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    check_op("mul_7x-3", 3'd0, 32'd7, 32'hffff_fffd);
    chk("mul_7x-3_val", result, 32'hffff_ffeb);
    idle(1);
    #1;
    chk("hold_done", done, 0);
    chk("hold_result", result, 32'hffff_ffeb);
    check_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000);
    check_op("mulhu_ff", 3'd3, 32'hffff_ffff, 32'hffff_ffff);
    check_op("mulhsu_ff", 3'd2, 32'hffff_ffff, 32'hffff_ffff);
    check_op("div_-7_2", 3'd4, 32'hffff_fff9, 32'd2);
    check_op("rem_-7_2", 3'd6, 32'hffff_fff9, 32'd2);
    check_op("divu_100_7", 3'd5, 32'd100, 32'd7);
    check_op("remu_100_7", 3'd7, 32'd100, 32'd7);
    check_op("div_5_0", 3'd4, 32'd5, 32'd0);
    check_op("rem_5_0", 3'd6, 32'd5, 32'd0);
    check_op("div_ovf", 3'd4, 32'h8000_0000, 32'hffff_ffff);
    check_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hffff_ffff);
    check_op("mul_0", 3'd0, 32'd0, 32'd1234);
    idle(1);

    // back-to-back: second start in the cycle right after done
    check_op("b2b_2x3", 3'd0, 32'd2, 32'd3);
    check_op("b2b_6x6", 3'd0, 32'd6, 32'd6);
    chk("b2b_6x6_val", result, 32'd36);
    idle(1);

    // reset mid-divide aborts with no done
    @(negedge clk);
    start = 1'b1; func3 = 3'd4; opA = 32'd100; opB = 32'd7;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    #1;
    chk("abort_stall", stall, 0);
    chk("abort_result", result, 0);
    dseen = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (done) dseen = 1;
    end
    chk("abort_no_done", dseen, 0);
    check_op("post_rst_3x4", 3'd0, 32'd3, 32'd4);
    chk("post_rst_val", result, 32'd12);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      check_op($sformatf("rnd%0d_f%0d", i, rf), rf, ra, rb);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
